// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: dataset-load, sample/prediction handshake and run-status signals of the trainer.
interface perceptron_trainer_if #(
    parameter int input_units = 2,
    parameter int num_samples = 4
);
    localparam int aw = (num_samples > 1) ? $clog2(num_samples) : 1;
    logic          load_en;
    logic [aw-1:0] load_addr;
    real           load_values [input_units];
    real           load_expected;
    logic          start;
    logic          sample_valid;
    logic          sample_ready;
    real           values [input_units];
    real           expected;
    logic          pred_valid;
    real           prediction;
    logic          grad_valid;
    real           error_gradient;
    logic          training;
    logic [31:0]   epoch_count;
    real           epoch_cost;
    logic          done;
    modport master (
        input  load_en, load_addr, load_values, load_expected, start,
               sample_ready, pred_valid, prediction,
        output sample_valid, values, expected, grad_valid, error_gradient,
               training, epoch_count, epoch_cost, done
    );
    modport slave (
        output load_en, load_addr, load_values, load_expected, start,
               sample_ready, pred_valid, prediction,
        input  sample_valid, values, expected, grad_valid, error_gradient,
               training, epoch_count, epoch_cost, done
    );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: replays a stored dataset for num_epochs passes and returns the BCE gradient per sample.
// Optional COST_ACCUM_EN adds a per-epoch mean BCE cost; without it epoch_cost is 0.0.
module perceptron_trainer #(
    parameter int  input_units = 2,
    parameter int  num_samples = 4,
    parameter int  num_epochs  = 5,
    parameter real epsilon     = 1e-8
) (
    input logic clk,
    input logic rst,
    perceptron_trainer_if.master bus
);
    localparam int aw = (num_samples > 1) ? $clog2(num_samples) : 1;
    localparam logic [aw:0]   ns_lim   = (aw+1)'(num_samples);
    localparam logic [aw-1:0] last_idx = aw'(num_samples - 1);
    typedef enum logic [2:0] {IDLE, PRESENT, WAIT_PRED, EPOCH_END, DONE} state_t;
    state_t        state_q, state_d;
    logic [aw-1:0] idx_q, idx_d, idx_nx;
    logic [31:0]   epoch_q, epoch_d;
    logic          sample_valid_q, sample_valid_d;
    logic          grad_valid_q, grad_valid_d;
    logic          training_q, training_d;
    logic          done_q, done_d;
    logic          load_ok;
    real           grad_q, grad_d;
    real           expected_q, expected_d;
    real           values_q [input_units];
    real           values_d [input_units];
    real           tab_val_q [num_samples][input_units];
    real           tab_val_d [num_samples][input_units];
    real           tab_exp_q [num_samples];
    real           tab_exp_d [num_samples];
    real           p_clamp;
`ifdef COST_ACCUM_EN
    real           acc_q, acc_d, cost_q, cost_d;
`endif
    assign p_clamp = bus.prediction < 0.0 ? 0.0 : (bus.prediction > 1.0 ? 1.0 : bus.prediction);
    assign load_ok = bus.load_en && !training_q && ({1'b0, bus.load_addr} < ns_lim);
    assign idx_nx  = idx_q + 1'b1;
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        epoch_d        = epoch_q;
        sample_valid_d = sample_valid_q;
        grad_valid_d   = 1'b0;
        training_d     = training_q;
        done_d         = done_q;
        grad_d         = grad_q;
        expected_d     = expected_q;
        values_d       = values_q;
        tab_val_d      = tab_val_q;
        tab_exp_d      = tab_exp_q;
`ifdef COST_ACCUM_EN
        acc_d          = acc_q;
        cost_d         = cost_q;
`endif
        if (load_ok) begin
            tab_val_d[bus.load_addr] = bus.load_values;
            tab_exp_d[bus.load_addr] = bus.load_expected;
        end
        case (state_q)
            IDLE, DONE: if (bus.start && !bus.load_en) begin
                state_d        = PRESENT;
                idx_d          = '0;
                epoch_d        = '0;
                done_d         = 1'b0;
                training_d     = 1'b1;
                sample_valid_d = 1'b1;
                values_d       = tab_val_q[0];
                expected_d     = tab_exp_q[0];
`ifdef COST_ACCUM_EN
                acc_d          = 0.0;
`endif
            end
            PRESENT: if (bus.sample_ready) begin
                state_d        = WAIT_PRED;
                sample_valid_d = 1'b0;
            end
            WAIT_PRED: if (bus.pred_valid) begin
                grad_valid_d = 1'b1;
                grad_d = -(expected_q / (p_clamp + epsilon) - (1.0 - expected_q) / (1.0 - p_clamp + epsilon));
`ifdef COST_ACCUM_EN
                acc_d = acc_q - (expected_q * $ln(p_clamp + epsilon) + (1.0 - expected_q) * $ln(1.0 - p_clamp + epsilon));
`endif
                if (idx_q == last_idx) state_d = EPOCH_END;
                else begin
                    state_d        = PRESENT;
                    idx_d          = idx_nx;
                    sample_valid_d = 1'b1;
                    values_d       = tab_val_q[idx_nx];
                    expected_d     = tab_exp_q[idx_nx];
                end
            end
            EPOCH_END: begin
                epoch_d = epoch_q + 1'b1;
`ifdef COST_ACCUM_EN
                cost_d  = acc_q / num_samples;
                acc_d   = 0.0;
`endif
                if (epoch_d == 32'(num_epochs)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    training_d = 1'b0;
                end else begin
                    state_d        = PRESENT;
                    idx_d          = '0;
                    sample_valid_d = 1'b1;
                    values_d       = tab_val_q[0];
                    expected_d     = tab_exp_q[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            epoch_q        <= '0;
            sample_valid_q <= 1'b0;
            grad_valid_q   <= 1'b0;
            training_q     <= 1'b0;
            done_q         <= 1'b0;
            grad_q         <= 0.0;
            expected_q     <= 0.0;
            for (int i = 0; i < input_units; i++) values_q[i] <= 0.0;
            for (int i = 0; i < num_samples; i++) begin
                tab_exp_q[i] <= 0.0;
                for (int j = 0; j < input_units; j++) tab_val_q[i][j] <= 0.0;
            end
`ifdef COST_ACCUM_EN
            acc_q          <= 0.0;
            cost_q         <= 0.0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            epoch_q        <= epoch_d;
            sample_valid_q <= sample_valid_d;
            grad_valid_q   <= grad_valid_d;
            training_q     <= training_d;
            done_q         <= done_d;
            grad_q         <= grad_d;
            expected_q     <= expected_d;
            values_q       <= values_d;
            tab_val_q      <= tab_val_d;
            tab_exp_q      <= tab_exp_d;
`ifdef COST_ACCUM_EN
            acc_q          <= acc_d;
            cost_q         <= cost_d;
`endif
        end
    end
    for (genvar i = 0; i < input_units; i++) begin : g_val
        assign bus.values[i] = values_q[i];
    end
    assign bus.sample_valid   = sample_valid_q;
    assign bus.expected       = expected_q;
    assign bus.grad_valid     = grad_valid_q;
    assign bus.error_gradient = grad_q;
    assign bus.training       = training_q;
    assign bus.epoch_count    = epoch_q;
    assign bus.done           = done_q;
`ifdef COST_ACCUM_EN
    assign bus.epoch_cost     = cost_q;
`else
    assign bus.epoch_cost     = 0.0;
`endif
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed bench with a behavioural model checking the 4-sample instance every cycle,
// plus literal checks on a 1-sample/1-epoch instance.
module tb_perceptron_trainer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    localparam real eps = 1e-8;
    perceptron_trainer_if #(.input_units(2), .num_samples(1)) s ();
    perceptron_trainer_if #(.input_units(2), .num_samples(4)) b ();
    perceptron_trainer #(.input_units(2), .num_samples(1), .num_epochs(1)) u_s (.clk(clk), .rst(rst), .bus(s.master));
    perceptron_trainer #(.input_units(2), .num_samples(4), .num_epochs(5)) u_b (.clk(clk), .rst(rst), .bus(b.master));
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input real act, input real exp, input real tol);
        n_chk++;
        if ((act > exp ? act - exp : exp - act) <= tol) n_pass++;
        else $display("FAIL %s: got %g expected %g", nm, act, exp);
    endtask
    function automatic real rtol(input real x);
        return 1e-6 * (x < 0.0 ? 1.0 - x : 1.0 + x);
    endfunction
    function automatic real clampp(input real p);
        return p < 0.0 ? 0.0 : (p > 1.0 ? 1.0 : p);
    endfunction
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    // Model of the 4-sample, 5-epoch instance: what a run must show, cycle by cycle.
    real m_tv [4][2];
    real m_te [4];
    bit  m_valid, m_wait, m_gap, m_busy, m_done, m_gv, mb;
    int  m_k, m_ep;
    real m_g, m_acc, m_cost, mp, me;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin m_te[i] = 0.0; m_tv[i][0] = 0.0; m_tv[i][1] = 0.0; end
            {m_valid, m_wait, m_gap, m_busy, m_done, m_gv} = '0;
            m_k = 0; m_ep = 0; m_g = 0.0; m_acc = 0.0; m_cost = 0.0;
        end else begin
            mb = m_busy;
            m_gv = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
                m_ep++;
`ifdef COST_ACCUM_EN
                m_cost = m_acc / 4.0;
                m_acc = 0.0;
`endif
                if (m_ep == 5) begin m_done = 1'b1; m_busy = 1'b0; end
                else m_valid = 1'b1;
            end else if (m_wait) begin
                if (b.pred_valid) begin
                    mp = clampp(b.prediction);
                    me = m_te[(m_k - 1) % 4];
                    m_g = (1.0 - me) / (1.0 - mp + eps) - me / (mp + eps);
                    m_acc += -(me * $ln(mp + eps) + (1.0 - me) * $ln(1.0 - mp + eps));
                    m_gv = 1'b1;
                    m_wait = 1'b0;
                    if (m_k % 4 == 0) m_gap = 1'b1;
                    else m_valid = 1'b1;
                end
            end else if (m_valid) begin
                if (b.sample_ready) begin m_valid = 1'b0; m_wait = 1'b1; m_k++; end
            end else if (!m_busy && b.start && !b.load_en) begin
                m_busy = 1'b1; m_done = 1'b0; m_ep = 0; m_k = 0; m_valid = 1'b1; m_acc = 0.0;
            end
            if (b.load_en && !mb) begin
                m_tv[b.load_addr][0] = b.load_values[0];
                m_tv[b.load_addr][1] = b.load_values[1];
                m_te[b.load_addr] = b.load_expected;
            end
        end
    end
    bit cmp_en = 1'b0;
    int strobes = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_sample_valid", b.sample_valid, m_valid, 0.0);
            if (m_valid) begin
                chk("m_values0", b.values[0], m_tv[m_k % 4][0], 0.0);
                chk("m_values1", b.values[1], m_tv[m_k % 4][1], 0.0);
                chk("m_expected", b.expected, m_te[m_k % 4], 0.0);
            end
            chk("m_grad_valid", b.grad_valid, m_gv, 0.0);
            if (m_gv) chk("m_gradient", b.error_gradient, m_g, rtol(m_g));
            chk("m_training", b.training, m_busy, 0.0);
            chk("m_done", b.done, m_done, 0.0);
            chk("m_epoch_count", b.epoch_count, m_ep, 0.0);
            chk("m_epoch_cost", b.epoch_cost, m_cost, 1e-6);
            if (b.grad_valid) strobes++;
        end
    end
    task automatic small_run(input real e, input real p, input real g_exp, input string nm);
        s.load_en = 1; s.load_addr = '0; s.load_values[0] = 0.3; s.load_values[1] = 0.7; s.load_expected = e;
        cyc();
        s.load_en = 0; s.start = 1;
        cyc();
        s.start = 0;
        chk({nm, "_sample_valid"}, s.sample_valid, 1, 0.0);
        chk({nm, "_values1"}, s.values[1], 0.7, 0.0);
        chk({nm, "_expected"}, s.expected, e, 0.0);
        s.sample_ready = 1;
        cyc();
        s.sample_ready = 0; s.pred_valid = 1; s.prediction = p;
        cyc();
        s.pred_valid = 0;
        chk({nm, "_grad_valid"}, s.grad_valid, 1, 0.0);
        chk({nm, "_gradient"}, s.error_gradient, g_exp, rtol(g_exp));
        cyc();
        chk({nm, "_grad_valid_drop"}, s.grad_valid, 0, 0.0);
        chk({nm, "_gradient_hold"}, s.error_gradient, g_exp, rtol(g_exp));
        chk({nm, "_done"}, s.done, 1, 0.0);
        chk({nm, "_epoch_count"}, s.epoch_count, 1, 0.0);
        chk({nm, "_training"}, s.training, 0, 0.0);
    endtask
    task automatic serve(input real p, input string nm);
        int w = 0;
        while (!b.sample_valid && w < 10) begin cyc(); w++; end
        if (!b.sample_valid) chk({nm, "_sample_timeout"}, 0, 1, 0.0);
        cyc();
        b.sample_ready = 1;
        cyc();
        b.sample_ready = 0; b.pred_valid = 1; b.prediction = p;
        cyc();
        b.pred_valid = 0;
    endtask
    task automatic load_b(input int a, input real v0, input real v1, input real e);
        b.load_en = 1; b.load_addr = 2'(a); b.load_values[0] = v0; b.load_values[1] = v1; b.load_expected = e;
        cyc();
        b.load_en = 0;
    endtask
    initial begin
        int base, w;
        s.load_en = 0; s.load_addr = '0; s.load_values[0] = 0.0; s.load_values[1] = 0.0; s.load_expected = 0.0;
        s.start = 0; s.sample_ready = 0; s.pred_valid = 0; s.prediction = 0.0;
        b.load_en = 0; b.load_addr = '0; b.load_values[0] = 0.0; b.load_values[1] = 0.0; b.load_expected = 0.0;
        b.start = 0; b.sample_ready = 0; b.pred_valid = 0; b.prediction = 0.0;
        cyc(); cyc();
        rst = 1;
        cyc();
        chk("rst_sample_valid", b.sample_valid, 0, 0.0);
        chk("rst_training", b.training, 0, 0.0);
        chk("rst_done", s.done, 0, 0.0);
        chk("rst_epoch_count", b.epoch_count, 0, 0.0);
        chk("rst_epoch_cost", b.epoch_cost, 0.0, 0.0);
        cmp_en = 1;
        small_run(1.0, 0.5, -2.0, "t1");
        small_run(0.0, 0.5, 2.0, "t2a");
        small_run(0.0, 1.2, 1.0e8, "t2b");
        load_b(0, 1.0, 1.0, 1.0);
        load_b(1, 1.0, 0.0, 0.0);
        load_b(2, 0.0, 1.0, 0.0);
        load_b(3, 0.0, 0.0, 0.0);
        b.start = 1;
        cyc();
        b.start = 0;
        base = strobes;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin b.load_en = 1; b.load_addr = 2'd0; b.load_values[0] = 9.0; b.load_values[1] = 9.0; end
            if (i == 2) b.start = 1;
            serve(0.07 * i - 0.1, "t3");
            b.load_en = 0; b.start = 0;
        end
        w = 0;
        while (!b.done && w < 10) begin cyc(); w++; end
        chk("t3_strobes", strobes - base, 20, 0.0);
        chk("t3_epoch_count", b.epoch_count, 5, 0.0);
        chk("t3_training", b.training, 0, 0.0);
        chk("t3_done", b.done, 1, 0.0);
        b.start = 1;
        cyc();
        b.start = 0;
        for (int c = 0; c < 7; c++) begin
            chk("t4_sample_valid", b.sample_valid, 1, 0.0);
            chk("t4_values0", b.values[0], 1.0, 0.0);
            chk("t4_values1", b.values[1], 1.0, 0.0);
            b.pred_valid = (c == 3); b.prediction = 0.9;
            cyc();
            b.pred_valid = 0;
            chk("t4_no_grad", b.grad_valid, 0, 0.0);
        end
        b.sample_ready = 1;
        cyc();
        b.sample_ready = 0;
        #2 rst = 0;
        #1;
        chk("t5_sample_valid", b.sample_valid, 0, 0.0);
        chk("t5_grad_valid", b.grad_valid, 0, 0.0);
        chk("t5_training", b.training, 0, 0.0);
        chk("t5_epoch_count", b.epoch_count, 0, 0.0);
        chk("t5_gradient", b.error_gradient, 0.0, 0.0);
        cyc();
        rst = 1;
        cyc();
        b.start = 1;
        cyc();
        b.start = 0;
        chk("t5_restart_valid", b.sample_valid, 1, 0.0);
        chk("t5_cleared_values0", b.values[0], 0.0, 0.0);
        chk("t5_cleared_expected", b.expected, 0.0, 0.0);
        rst = 0;
        cyc();
        rst = 1;
        cyc();
        load_b(0, 0.5, 0.25, 1.0);
        load_b(1, 0.5, 0.25, 1.0);
        load_b(2, 0.5, 0.25, 1.0);
        b.start = 1;
        load_b(3, 0.5, 0.25, 1.0);
        b.start = 0;
        chk("t6_start_with_load", b.training, 0, 0.0);
        b.start = 1;
        cyc();
        b.start = 0;
        for (int i = 0; i < 4; i++) serve(0.5, "t6");
        w = 0;
        while (b.epoch_count != 1 && w < 10) begin cyc(); w++; end
        chk("t6_epoch_count", b.epoch_count, 1, 0.0);
`ifdef COST_ACCUM_EN
        chk("t6_epoch_cost", b.epoch_cost, 0.693147, 1e-5);
`else
        chk("t6_epoch_cost", b.epoch_cost, 0.0, 0.0);
`endif
        rst = 0;
        cyc();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
